nibble_serial_adder: RTL and testbench

Multi-nibble sequencer built around the existing 4-bit ripple adder `adder_16`. It accepts two wide operands and a carry-in through a valid/ready handshake, then drives `adder_16` one nibble per cycle. On each cycle it captures the adder's `s` and `cout`, chains the carry forward, and presents the assembled wide sum downstream. It sits directly upstream of `adder_16`, feeding it `a`/`b`/`cin`, and directly downstream of it, consuming `s`/`cout`.

---
 rtl/nibble_serial_adder_pkg.sv | 18 +
 rtl/nibble_serial_adder_if.sv | 30 +++
 rtl/adder_16.sv | 21 ++
 rtl/nibble_serial_adder.sv | 94 +++++++++
 tb/tb_nibble_serial_adder.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encodings, slice width
// and the index-register sizing helper.
package nibble_serial_adder_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // idx needs clog2(n) bits, but never fewer than one.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle between the producer, the nibble-serial
// adder and its consumer.
interface nibble_serial_adder_if #(
  parameter int unsigned NIBBLES = 4
);
  import nibble_serial_adder_pkg::*;

  localparam int unsigned W = NIB_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output in_valid, op_a, op_b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, op_a, op_b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/adder_16.sv
// Existing 4-bit ripple-carry adder slice.
module adder_16 (
  output logic [3:0] s,
  output logic       cout,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder built by stepping a single 4-bit adder_16 across the operands,
// one nibble per clock, with a valid/ready handshake on both sides.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus
);

  localparam int unsigned W     = NIB_W * NIBBLES;
  localparam int unsigned IDX_W = idx_width(NIBBLES);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [W-1:0]       a_q, b_q, sum_q;
  logic               carry_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic               accept_c;
  logic               last_c;
  logic [NIB_W-1:0]   nib_a_c, nib_b_c, nib_s_c;
  logic               nib_cout_c;

  assign nib_a_c = a_q[NIB_W*idx_q +: NIB_W];
  assign nib_b_c = b_q[NIB_W*idx_q +: NIB_W];
  assign last_c  = (idx_q == IDX_W'(NIBBLES - 1));

  adder_16 u_adder (
    .s    (nib_s_c),
    .cout (nib_cout_c),
    .a    (nib_a_c),
    .b    (nib_b_c),
    .cin  (carry_q)
  );

  // Next-state decode; handshakes are qualified by the registered flags.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          accept_c = 1'b1;
          state_d  = ST_ADD;
        end
      end
      ST_ADD: begin
        if (last_c) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_valid_q && bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      if (accept_c) begin
        a_q     <= bus.op_a;
        b_q     <= bus.op_b;
        carry_q <= bus.cin;
        idx_q   <= '0;
        sum_q   <= '0;
      end else if (state_q == ST_ADD) begin
        sum_q[NIB_W*idx_q +: NIB_W] <= nib_s_c;
        carry_q                     <= nib_cout_c;
        if (!last_c) idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: vector table at NIBBLES=4 plus
// backpressure, reset-abort and single-nibble sequences.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.NIBBLES(4)) m  ();
  nibble_serial_adder_if #(.NIBBLES(1)) m1 ();

  nibble_serial_adder #(.NIBBLES(4)) dut  (.clk(clk), .rst(rst), .bus(m));
  nibble_serial_adder #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(m1));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs [8];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one operand set, then count edges until out_valid (out_ready untouched).
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic c,
                         output logic [15:0] s, output logic co, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!m.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(m.in_ready), 32'd1);
    m.op_a     = a;
    m.op_b     = b;
    m.cin      = c;
    m.in_valid = 1'b1;
    @(posedge clk);
    #1 m.in_valid = 1'b0;
    lat = 0;
    while (!m.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    s  = m.sum;
    co = m.cout;
  endtask

  logic [15:0] s;
  logic        co;
  int          lat;

  initial begin
    vecs[0] = '{16'h00AA, 16'h0001, 1'b0, 16'h00AB, 1'b0};
    vecs[1] = '{16'h000F, 16'h0002, 1'b0, 16'h0011, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

    m.in_valid  = 1'b0; m.op_a  = '0; m.op_b  = '0; m.cin  = 1'b0; m.out_ready  = 1'b1;
    m1.in_valid = 1'b0; m1.op_a = '0; m1.op_b = '0; m1.cin = 1'b0; m1.out_ready = 1'b1;

    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(m.out_valid), 32'd0);
    check("rst_sum",       32'(m.sum),       32'd0);
    check("rst_cout",      32'(m.cout),      32'd0);
    check("rst_in_ready",  32'(m.in_ready),  32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("post_rst_in_ready", 32'(m.in_ready), 32'd1);

    // Vector table, consumer always ready
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].c, s, co, lat);
      check($sformatf("vec%0d_sum", i),  32'(s),   32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i), 32'(co),  32'(vecs[i].exp_cout));
      check($sformatf("vec%0d_lat", i),  32'(lat), 32'd4);
      @(posedge clk);
      #1 check($sformatf("vec%0d_drain", i), 32'(m.out_valid), 32'd0);
    end

    // Backpressure with stray in_valid pulses during ADD and DONE
    m.out_ready = 1'b0;
    @(negedge clk);
    m.op_a = 16'h00AA; m.op_b = 16'h0001; m.cin = 1'b0; m.in_valid = 1'b1;
    @(posedge clk);
    #1 m.in_valid = 1'b0;
    @(negedge clk);
    m.op_a = 16'h1111; m.op_b = 16'h2222; m.cin = 1'b1; m.in_valid = 1'b1;
    @(negedge clk) m.in_valid = 1'b0;
    lat = 0;
    while (!m.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_sum", 32'(m.sum), 32'h00AB);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m.in_valid = 1'b1;
      check($sformatf("bp%0d_valid", k), 32'(m.out_valid), 32'd1);
      check($sformatf("bp%0d_sum", k),   32'(m.sum),       32'h00AB);
      check($sformatf("bp%0d_cout", k),  32'(m.cout),      32'd0);
      check($sformatf("bp%0d_ready", k), 32'(m.in_ready),  32'd0);
    end
    @(negedge clk);
    m.in_valid  = 1'b0;
    m.out_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_release_valid", 32'(m.out_valid), 32'd0);
    @(posedge clk);
    #1 check("bp_release_ready", 32'(m.in_ready), 32'd1);

    // Reset after two ADD cycles discards the transaction
    @(negedge clk);
    m.op_a = 16'h5555; m.op_b = 16'h1111; m.cin = 1'b0; m.in_valid = 1'b1;
    @(posedge clk);
    #1 m.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid", 32'(m.out_valid), 32'd0);
    check("midrst_sum",   32'(m.sum),       32'd0);
    check("midrst_cout",  32'(m.cout),      32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("midrst_in_ready", 32'(m.in_ready), 32'd1);
    run_txn(16'h1234, 16'h4321, 1'b0, s, co, lat);
    check("midrst_next_sum",  32'(s),   32'h5555);
    check("midrst_next_cout", 32'(co),  32'd0);
    check("midrst_next_lat",  32'(lat), 32'd4);

    // Single-nibble build
    @(negedge clk);
    check("n1_in_ready", 32'(m1.in_ready), 32'd1);
    m1.op_a = 4'hA; m1.op_b = 4'h7; m1.cin = 1'b1; m1.in_valid = 1'b1;
    @(posedge clk);
    #1 m1.in_valid = 1'b0;
    lat = 0;
    while (!m1.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("n1_sum",  32'(m1.sum),  32'h2);
    check("n1_cout", 32'(m1.cout), 32'd1);
    check("n1_lat",  32'(lat),     32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
